// File: rtl/spi_dac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_dac_tx
//  Brief    : SPI write master for serial DACs with a one-entry pending word.
//  Revision : 1.0
// ============================================================================
module spi_dac_tx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clk_div,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             busy,
    output logic             clk_spi,
    output logic             cs_spi,
    output logic             sd_spi,
    output logic             done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEAD  = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    localparam int              c_BW       = $clog2(WIDTH);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [31:0]      r_cnt;
    logic [31:0]      r_div;
    logic [c_BW-1:0]  r_bit;
    logic             r_phase;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;

    logic        w_cnt_last;
    logic        w_accept;
    logic        w_load_direct;
    logic        w_unload;
    logic        w_load;
    logic [31:0] w_div_eff;

    assign w_div_eff     = (clk_div == 32'd0) ? 32'd1 : clk_div;
    assign w_cnt_last    = (r_cnt == r_div - 32'd1);
    assign w_unload      = (r_state == c_GAP) && w_cnt_last && r_pend_valid;
    assign w_accept      = start && ready;
    assign w_load_direct = w_accept && (r_state == c_IDLE);
    assign w_load        = w_load_direct || w_unload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_load_direct) w_state_nxt = c_LEAD;
            c_LEAD:  if (w_cnt_last) w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_cnt_last && r_phase && (r_bit == c_BIT_LAST)) w_state_nxt = c_TRAIL;
            c_TRAIL: if (w_cnt_last) w_state_nxt = c_GAP;
            c_GAP:   if (w_cnt_last) w_state_nxt = w_unload ? c_LEAD : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // r_phase=0 is the low half of an SPI clock period; data advances on each rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 32'd0;
            r_div        <= 32'd1;
            r_bit        <= '0;
            r_phase      <= 1'b0;
            r_shift      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) || w_cnt_last) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_load) begin
                r_div   <= w_div_eff;
                r_shift <= w_load_direct ? data : r_pend;
                r_bit   <= '0;
                r_phase <= 1'b0;
            end else if ((r_state == c_SHIFT) && w_cnt_last) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                end else if (r_bit != c_BIT_LAST) begin
                    r_bit <= r_bit + c_BW'(1);
                end
            end

            // A word arriving on the unload cycle refills the slot just vacated.
            if (w_accept && !w_load_direct) begin
                r_pend       <= data;
                r_pend_valid <= 1'b1;
            end else if (w_unload) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        ready   = !r_pend_valid || w_unload;
        busy    = (r_state != c_IDLE) || r_pend_valid;
        cs_spi  = (r_state == c_IDLE) || (r_state == c_GAP);
        clk_spi = !((r_state == c_SHIFT) && !r_phase);
        sd_spi  = ((r_state == c_LEAD) || (r_state == c_SHIFT)) && r_shift[WIDTH-1];
        done    = (r_state == c_GAP) && (r_cnt == 32'd0);
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_dac_tx
//  Brief    : Scoreboard bench for spi_dac_tx; words pushed on acceptance are
//             compared with the bits captured on falling SPI clock edges.
//  Revision : 1.0
// ============================================================================
module tb_spi_dac_tx;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div = 32'd2;
    logic        start = 1'b0;
    logic [15:0] data = 16'h0;
    logic        ready;
    logic        busy;
    logic        clk_spi;
    logic        cs_spi;
    logic        sd_spi;
    logic        done;

    spi_dac_tx #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_div (clk_div),
        .start   (start),
        .data    (data),
        .ready   (ready),
        .busy    (busy),
        .clk_spi (clk_spi),
        .cs_spi  (cs_spi),
        .sd_spi  (sd_spi),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int          d;
        bit          gap;
    } entry_t;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: captures the word, frame length and inter-frame gap.
    logic        prev_cs = 1'b1;
    logic        prev_clk = 1'b1;
    logic        prev_done = 1'b0;
    int          low_cnt = 0;
    int          gap_cnt = 0;
    int          bits = 0;
    logic [15:0] word = 16'h0;

    always @(negedge clk) begin
        entry_t e;
        if (rst) begin
            prev_cs   = 1'b1;
            prev_clk  = 1'b1;
            prev_done = 1'b0;
            low_cnt   = 0;
            gap_cnt   = 0;
            bits      = 0;
        end else begin
            if (done) begin
                n_done++;
                check("done_single", 32'(prev_done), 32'd0);
                check("done_on_cs_rise", 32'(cs_spi && !prev_cs), 32'd1);
            end
            if (!cs_spi && prev_cs) begin
                n_start++;
                bits    = 0;
                word    = 16'h0;
                low_cnt = 0;
                check("frame_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0 && sb[0].gap) check("cs_gap", 32'(gap_cnt), 32'(sb[0].d));
            end
            if (!cs_spi) begin
                low_cnt++;
                if (prev_clk && !clk_spi) begin
                    word = {word[14:0], sd_spi};
                    bits++;
                end
            end
            if (cs_spi && !prev_cs) begin
                check("done_at_end", 32'(done), 32'd1);
                check("end_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("word", 32'(word), 32'(e.w));
                    check("falls", 32'(bits), 32'd16);
                    check("cs_low_len", 32'(low_cnt), 32'((2 * WIDTH + 2) * e.d));
                end
                gap_cnt = 1;
            end else if (cs_spi && prev_cs) begin
                gap_cnt++;
            end
            prev_cs   = cs_spi;
            prev_clk  = clk_spi;
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds start until the DUT is ready, then records the expected frame.
    task automatic send(input logic [15:0] w, input int dd, input bit gap);
        int n = 0;
        start = 1'b1;
        data  = w;
        @(negedge clk);
        while (!ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 10000), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = 16'h0;
        sb.push_back('{w: w, d: dd, gap: gap});
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || !cs_spi) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 20000), 32'd1);
        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int s_start;
        int s_done;

        // Reset, with a start request that must be ignored.
        repeat (2) step();
        start = 1'b1;
        data  = 16'hFFFF;
        step();
        @(negedge clk);
        check("rst_cs", 32'(cs_spi), 32'd1);
        check("rst_clk", 32'(clk_spi), 32'd1);
        check("rst_sd", 32'(sd_spi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("start_in_rst_ignored", 32'(busy), 32'd0);
        step();

        // D=2, single frame with lead timing.
        clk_div = 32'd2;
        send(16'hA5C3, 2, 1'b0);
        @(negedge clk);
        check("lead_cs", 32'(cs_spi), 32'd0);
        check("lead_clk", 32'(clk_spi), 32'd1);
        check("lead_msb", 32'(sd_spi), 32'd1);
        @(negedge clk);
        check("lead_end_clk", 32'(clk_spi), 32'd1);
        @(negedge clk);
        check("first_fall", 32'(clk_spi), 32'd0);
        wait_idle();

        // clk_div=0 behaves as D=1.
        clk_div = 32'd0;
        send(16'hFFFF, 1, 1'b0);
        wait_idle();

        // D=3 with a second word queued mid-frame.
        clk_div = 32'd3;
        send(16'h1234, 3, 1'b0);
        repeat (8) step();
        send(16'h8001, 3, 1'b1);
        @(negedge clk);
        check("pend_ready", 32'(ready), 32'd0);
        check("pend_busy", 32'(busy), 32'd1);
        wait_idle();

        // Held start while pending is full, then a mid-frame clk_div change.
        clk_div = 32'd2;
        send(16'h1111, 2, 1'b0);
        send(16'h2222, 2, 1'b1);
        send(16'hDEAD, 2, 1'b1);
        wait_idle();
        send(16'h5A5A, 2, 1'b0);
        repeat (10) step();
        clk_div = 32'd7;
        wait_idle();
        clk_div = 32'd2;

        // Reset mid-frame with a word pending.
        send(16'h0F0F, 2, 1'b0);
        send(16'h3333, 2, 1'b1);
        repeat (17) step();
        s_start = n_start;
        s_done  = n_done;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_cs", 32'(cs_spi), 32'd1);
        check("abort_clk", 32'(clk_spi), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        repeat (200) step();
        check("abort_no_frame", 32'(n_start), 32'(s_start));
        check("abort_no_done", 32'(n_done), 32'(s_done));

        // D=1 stream of four words, each sent as soon as ready allows.
        clk_div = 32'd1;
        s_done  = n_done;
        send(16'h0001, 1, 1'b0);
        send(16'h8000, 1, 1'b1);
        send(16'h7FFE, 1, 1'b1);
        send(16'hC3C3, 1, 1'b1);
        wait_idle();
        check("stream_done_count", 32'(n_done - s_done), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
